// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: freeze on data-memory busy, squash on MEM redirect, bubble on load-use.
// Control outputs are combinational (0 cycles); state, counters and timeout update on the following clk edge.
module pipeline_hazard_controller #(
    parameter int CNT_WIDTH      = 16,
    parameter int FREEZE_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs_i,
    input  logic [4:0]           id_rt_i,
    input  logic                 id_uses_rt_i,
    input  logic                 ex_mem_read_i,
    input  logic [4:0]           ex_write_reg_i,
    input  logic                 mem_redirect_i,
    input  logic                 mem_busy_i,
    output logic                 pc_enable_o,
    output logic                 if_id_enable_o,
    output logic                 id_ex_enable_o,
    output logic                 ex_mem_enable_o,
    output logic                 mem_wb_enable_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_flush_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_AT = CNT_WIDTH'(FREEZE_TIMEOUT);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   freeze_count;
    logic [CNT_WIDTH-1:0]   freeze_count_inc;
    logic                   load_use;
    logic                   stall_inc;
    logic                   flush_inc;

    assign load_use = ex_mem_read_i && (ex_write_reg_i != 5'd0) &&
                      ((ex_write_reg_i == id_rs_i) ||
                       (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));

    assign freeze_count_inc = (freeze_count == CNT_MAX) ? CNT_MAX : freeze_count + 1'b1;

    always_comb begin
        state_nxt       = RUN;
        pc_enable_o     = 1'b1;
        if_id_enable_o  = 1'b1;
        id_ex_enable_o  = 1'b1;
        ex_mem_enable_o = 1'b1;
        mem_wb_enable_o = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        if (mem_busy_i) begin
            pc_enable_o     = 1'b0;
            if_id_enable_o  = 1'b0;
            id_ex_enable_o  = 1'b0;
            ex_mem_enable_o = 1'b0;
            mem_wb_enable_o = 1'b0;
            state_nxt       = FREEZE;
        end else if (mem_redirect_i && (state != FLUSH)) begin
            // In FLUSH the MEM slot holds a bubble, so a lingering redirect is stale.
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            flush_inc      = 1'b1;
            state_nxt      = FLUSH;
        end else if (load_use) begin
            pc_enable_o    = 1'b0;
            if_id_enable_o = 1'b0;
            id_ex_flush_o  = 1'b1;
            stall_inc      = 1'b1;
            state_nxt      = STALL;
        end

        if (!reset) begin
            pc_enable_o     = 1'b1;
            if_id_enable_o  = 1'b1;
            id_ex_enable_o  = 1'b1;
            ex_mem_enable_o = 1'b1;
            mem_wb_enable_o = 1'b1;
            if_id_flush_o   = 1'b0;
            id_ex_flush_o   = 1'b0;
            ex_mem_flush_o  = 1'b0;
            stall_inc       = 1'b0;
            flush_inc       = 1'b0;
            state_nxt       = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= RUN;
            stall_count_o <= '0;
            flush_count_o <= '0;
            freeze_count  <= '0;
            timeout_o     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (stall_inc && (stall_count_o != CNT_MAX))
                stall_count_o <= stall_count_o + 1'b1;
            if (flush_inc && (flush_count_o != CNT_MAX))
                flush_count_o <= flush_count_o + 1'b1;
            if (mem_busy_i) begin
                freeze_count <= freeze_count_inc;
                if (freeze_count_inc >= TIMEOUT_AT)
                    timeout_o <= 1'b1;
            end else begin
                freeze_count <= '0;
            end
        end
    end

    assign state_o = state;

endmodule
